// File: rtl/cordic_sequencer.sv
// Control stage for an iterative rotation-mode CORDIC: range-reduces the request angle,
// steps the external one-iteration stage ITERS times, then applies quadrant correction.
module cordic_sequencer #(
    parameter int ITERS   = 24,
    parameter int K_INIT  = 81504109,
    parameter int PI      = 6588397,
    parameter int HALF_PI = 3294199
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [24:0] in_theta,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [29:0] out_cos,
    output logic [29:0] out_sin,
    output logic        out_err,
    output logic [24:0] it_z,
    output logic [29:0] it_x,
    output logic [29:0] it_y,
    output logic [2:0]  it_quadrant,
    output logic [5:0]  it_i,
    input  logic [24:0] it_z_o,
    input  logic [29:0] it_x_o,
    input  logic [29:0] it_y_o,
    input  logic [2:0]  it_quadrant_o
);

    localparam logic signed [24:0] PI_S     = 25'(PI);
    localparam logic signed [24:0] NPI_S    = -PI_S;
    localparam logic signed [24:0] HPI_S    = 25'(HALF_PI);
    localparam logic signed [24:0] NHPI_S   = -HPI_S;
    localparam logic [5:0]         LAST_CNT = 6'(ITERS - 1);
    localparam logic [29:0]        K_X      = 30'(K_INIT);

    typedef enum logic [1:0] {IDLE, ITER, CORR, OUT} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [24:0] seed_z_q, seed_z_d;
    logic [29:0] seed_x_q, seed_x_d;
    logic [29:0] seed_y_q, seed_y_d;
    logic [2:0]  seed_quad_q, seed_quad_d;
    logic [29:0] cos_q, cos_d;
    logic [29:0] sin_q, sin_d;
    logic        err_q, err_d;
    logic        valid_q, valid_d;

    logic signed [24:0] theta_s, theta_c, z_red;
    logic [2:0]         q_red;
    logic               use_fb;

    // Clamp to [-pi, pi], then fold into [-pi/2, pi/2]; q[0] marks a fold (negate at the end).
    always_comb begin
        theta_s = $signed(in_theta);
        theta_c = theta_s;
        q_red   = 3'b000;
        if (theta_s > PI_S) begin
            theta_c  = PI_S;
            q_red[2] = 1'b1;
        end else if (theta_s < NPI_S) begin
            theta_c  = NPI_S;
            q_red[2] = 1'b1;
        end
        z_red = theta_c;
        if (theta_c > HPI_S) begin
            z_red    = theta_c - PI_S;
            q_red[0] = 1'b1;
        end else if (theta_c < NHPI_S) begin
            z_red    = theta_c + PI_S;
            q_red[0] = 1'b1;
        end
        q_red[1] = theta_c[24];
    end

    assign in_ready = (state_q == IDLE) && !rst;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        seed_z_d    = seed_z_q;
        seed_x_d    = seed_x_q;
        seed_y_d    = seed_y_q;
        seed_quad_d = seed_quad_q;
        cos_d       = cos_q;
        sin_d       = sin_q;
        err_d       = err_q;
        valid_d     = valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    seed_z_d    = z_red;
                    seed_x_d    = K_X;
                    seed_y_d    = '0;
                    seed_quad_d = q_red;
                    cnt_d       = '0;
                    state_d     = ITER;
                end
            end
            ITER: begin
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_CNT) state_d = CORR;
            end
            CORR: begin
                cos_d   = it_quadrant_o[0] ? -it_x_o : it_x_o;
                sin_d   = it_quadrant_o[0] ? -it_y_o : it_y_o;
                err_d   = it_quadrant_o[2];
                valid_d = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Iteration 0 starts from the seed; later iterations loop the stage's registered result back.
    assign use_fb      = (state_q == ITER) && (cnt_q != 6'd0);
    assign it_z        = use_fb ? it_z_o        : seed_z_q;
    assign it_x        = use_fb ? it_x_o        : seed_x_q;
    assign it_y        = use_fb ? it_y_o        : seed_y_q;
    assign it_quadrant = use_fb ? it_quadrant_o : seed_quad_q;
    assign it_i        = cnt_q;

    assign out_cos   = cos_q;
    assign out_sin   = sin_q;
    assign out_err   = err_q;
    assign out_valid = valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            seed_z_q    <= '0;
            seed_x_q    <= '0;
            seed_y_q    <= '0;
            seed_quad_q <= '0;
            cos_q       <= '0;
            sin_q       <= '0;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seed_z_q    <= seed_z_d;
            seed_x_q    <= seed_x_d;
            seed_y_q    <= seed_y_d;
            seed_quad_q <= seed_quad_d;
            cos_q       <= cos_d;
            sin_q       <= sin_d;
            err_q       <= err_d;
            valid_q     <= valid_d;
        end
    end

endmodule

// File: tb/tb_cordic_sequencer.sv
// Bench for cordic_sequencer: supplies a behavioural one-iteration CORDIC stage and checks
// results against a loop reference and against real-valued cos/sin.
module tb_cordic_sequencer;

    localparam int ITERS   = 24;
    localparam int K_INIT  = 81504109;
    localparam int PI      = 6588397;
    localparam int HALF_PI = 3294199;
    localparam longint TOL = 1024;  // fixed-point stage error vs ideal trig, in Q2.27 LSB

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic [24:0]        in_theta = '0;
    logic               in_ready, out_valid, out_err;
    logic signed [29:0] out_cos, out_sin;
    logic signed [24:0] it_z, it_z_o;
    logic signed [29:0] it_x, it_y, it_x_o, it_y_o;
    logic [2:0]         it_quadrant, it_quadrant_o;
    logic [5:0]         it_i;

    int n_chk = 0;
    int n_err = 0;
    int atan_tab[30];

    cordic_sequencer #(.ITERS(ITERS), .K_INIT(K_INIT), .PI(PI), .HALF_PI(HALF_PI)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_theta(in_theta),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_cos(out_cos), .out_sin(out_sin), .out_err(out_err),
        .it_z(it_z), .it_x(it_x), .it_y(it_y), .it_quadrant(it_quadrant), .it_i(it_i),
        .it_z_o(it_z_o), .it_x_o(it_x_o), .it_y_o(it_y_o), .it_quadrant_o(it_quadrant_o)
    );

    always #5 clk = ~clk;

    task automatic rot(input logic signed [24:0] z, input logic signed [29:0] x,
                       input logic signed [29:0] y, input int i,
                       output logic signed [24:0] zn, output logic signed [29:0] xn,
                       output logic signed [29:0] yn);
        logic signed [24:0] a;
        a = 25'(atan_tab[i]);
        if (z >= 0) begin
            xn = x - (y >>> i);
            yn = y + (x >>> i);
            zn = z - a;
        end else begin
            xn = x + (y >>> i);
            yn = y - (x >>> i);
            zn = z + a;
        end
    endtask

    // One registered CORDIC iteration, as the sequencer expects to find outside it.
    always @(posedge clk) begin : stage_model
        logic signed [24:0] zn;
        logic signed [29:0] xn, yn;
        int idx;
        idx = (int'(it_i) < 30) ? int'(it_i) : 29;
        rot(it_z, it_x, it_y, idx, zn, xn, yn);
        it_z_o        <= zn;
        it_x_o        <= xn;
        it_y_o        <= yn;
        it_quadrant_o <= it_quadrant;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint near(input longint obs, input longint exp, input longint tol);
        return ((obs - exp) <= tol && (exp - obs) <= tol) ? exp : obs;
    endfunction

    // Reference: clamp, fold by pi, iterate, unfold.
    task automatic golden(input int th, output int ec, output int es, output int ee,
                          output int tc);
        int z;
        bit flip;
        logic signed [24:0] vz;
        logic signed [29:0] vx, vy;
        tc = th;
        ee = 0;
        if (th > PI) begin tc = PI; ee = 1; end
        else if (th < -PI) begin tc = -PI; ee = 1; end
        z = tc;
        flip = 1'b0;
        if (tc > HALF_PI) begin z = tc - PI; flip = 1'b1; end
        else if (tc < -HALF_PI) begin z = tc + PI; flip = 1'b1; end
        vz = 25'(z);
        vx = 30'(K_INIT);
        vy = '0;
        for (int i = 0; i < ITERS; i++) rot(vz, vx, vy, i, vz, vx, vy);
        ec = flip ? -int'(vx) : int'(vx);
        es = flip ? -int'(vy) : int'(vy);
    endtask

    task automatic run(input int th, input int hold);
        int ec, es, ee, tc, lat, w, rc, rs;
        real ang;
        golden(th, ec, es, ee, tc);
        ang = real'(tc) / 2097152.0;
        rc  = int'($cos(ang) * 134217728.0);
        rs  = int'($sin(ang) * 134217728.0);
        w = 0;
        while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
        chk("ready_wait", longint'(in_ready), 1);
        in_valid = 1'b1;
        in_theta = 25'(th);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_ready", longint'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            out_ready = (lat < 4);
            @(posedge clk); #1;
            lat++;
        end
        out_ready = 1'b0;
        chk("latency", lat, ITERS + 1);
        chk("cos", out_cos, ec);
        chk("sin", out_sin, es);
        chk("err", longint'(out_err), ee);
        chk("cos_real", near(out_cos, rc, TOL), rc);
        chk("sin_real", near(out_sin, rs, TOL), rs);
        repeat (hold) begin
            in_valid = 1'b1;
            in_theta = 25'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (hold > 0) begin
            chk("hold_valid", longint'(out_valid), 1);
            chk("hold_ready", longint'(in_ready), 0);
            chk("hold_cos", out_cos, ec);
            chk("hold_sin", out_sin, es);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_clr", longint'(out_valid), 0);
        chk("ready_back", longint'(in_ready), 1);
        chk("cos_keep", out_cos, ec);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int dir[9] = '{0, 3294199, 6588397, -4941298, 1647099, 8000000, -8388608,
                       -3294199, -6588397};
        for (int i = 0; i < 30; i++)
            atan_tab[i] = int'($atan(1.0 / (2.0 ** i)) * 2097152.0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_ready", longint'(in_ready), 0);
        chk("rst_cos", out_cos, 0);
        chk("rst_err", longint'(out_err), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", longint'(in_ready), 1);

        foreach (dir[i]) run(dir[i], 0);
        run(1647099, 10);
        for (int n = 0; n < 20; n++)
            run(int'($signed(25'($urandom))), int'($urandom_range(0, 3)));

        // Abort mid-iteration: nothing may surface, previous result registers clear.
        in_valid = 1'b1;
        in_theta = 25'(12345);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", longint'(in_ready), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_ready_back", longint'(in_ready), 1);
        chk("mid_rst_cos", out_cos, 0);
        repeat (30) @(posedge clk);
        #1;
        chk("mid_rst_no_valid", longint'(out_valid), 0);
        run(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
